btn_bank_debouncer: RTL and testbench

Parametrised N-channel push-button conditioner for the user-input path. Each channel synchronises, debounces and classifies a raw button. It then emits single-cycle press events, an optional release-mode event, a long-press level and auto-repeat pulses. This lets game logic treat every button through one uniform event interface. All channels are independent and evaluated every clock; there is no shared arbitration.

---
 rtl/btn_bank_debouncer.sv | 147 ++++++++++++++
 tb/tb_btn_bank_debouncer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_bank_debouncer.sv
// btn_bank_debouncer: N-channel button synchroniser, debouncer and press/long/repeat event generator.
module btn_bank_debouncer #(
    parameter int N_BTN            = 4,
    parameter int CLK_HZ           = 50_000_000,
    parameter int DEBOUNCE_MS      = 5,
    parameter int HOLD_MS          = 500,
    parameter int REPEAT_MS        = 100,
    parameter int PRESS_ON_RELEASE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_BTN-1:0] btn_long
);
    localparam int MS        = CLK_HZ / 1000;
    localparam int DB_CLKS   = MS * DEBOUNCE_MS;
    localparam int HOLD_CLKS = MS * HOLD_MS;
    localparam int REP_CLKS  = MS * REPEAT_MS;
    localparam int MAX_DH    = DB_CLKS > HOLD_CLKS ? DB_CLKS : HOLD_CLKS;
    localparam int MAX_C     = MAX_DH > REP_CLKS ? MAX_DH : REP_CLKS;
    localparam int CW        = MAX_C < 2 ? 1 : $clog2(MAX_C);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DB_M1   = CW'(DB_CLKS - 1);
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CLKS - 1);
    localparam logic [CW-1:0] REP_M1  = CW'(REP_CLKS > 0 ? REP_CLKS - 1 : 0);
    localparam logic          REP_EN  = REP_CLKS > 0;
    localparam logic          POR     = PRESS_ON_RELEASE != 0;

    if (DB_CLKS < 1) begin : g_bad_db
        $error("btn_bank_debouncer: debounce count is zero");
    end
    if (HOLD_CLKS < 1) begin : g_bad_hold
        $error("btn_bank_debouncer: hold count is zero");
    end
    if (N_BTN < 1 || N_BTN > 16) begin : g_bad_n
        $error("btn_bank_debouncer: N_BTN out of range");
    end

    typedef enum logic [2:0] {LOW = 3'd0, RISE = 3'd1, HIGH = 3'd2, FALL = 3'd3} state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_t        st_q, st_d;
        logic          s1_q, s2_q;
        logic [CW-1:0] db_q, db_d, hold_q, hold_d, rep_q, rep_d;
        logic          lvl_q, lvl_d, long_q, long_d, press_q, press_d, rpt_q, rpt_d;

        always_comb begin
            st_d    = st_q;
            db_d    = db_q;
            hold_d  = hold_q;
            rep_d   = rep_q;
            lvl_d   = lvl_q;
            long_d  = long_q;
            press_d = 1'b0;
            rpt_d   = 1'b0;
            case (st_q)
                LOW: begin
                    if (s2_q) begin
                        st_d = RISE;
                        db_d = ONE;
                    end
                end
                RISE: begin
                    if (!s2_q) begin
                        st_d = LOW;
                        db_d = '0;
                    end else if (db_q == DB_M1) begin
                        st_d    = HIGH;
                        db_d    = '0;
                        hold_d  = '0;
                        lvl_d   = 1'b1;
                        press_d = !POR;
                    end else begin
                        db_d = db_q + ONE;
                    end
                end
                HIGH, FALL: begin
                    if (hold_q != HOLD_M1) hold_d = hold_q + ONE;
                    // the repeat phase restarts on the edge long first rises
                    if (hold_q == HOLD_M1 && !long_q) begin
                        long_d = 1'b1;
                        rpt_d  = REP_EN;
                        rep_d  = '0;
                    end else if (long_q && REP_EN) begin
                        rpt_d = rep_q == REP_M1;
                        rep_d = rep_q == REP_M1 ? '0 : rep_q + ONE;
                    end
                    if (st_q == HIGH) begin
                        if (!s2_q) begin
                            st_d = FALL;
                            db_d = ONE;
                        end
                    end else if (s2_q) begin
                        st_d = HIGH;
                        db_d = '0;
                    end else if (db_q == DB_M1) begin
                        st_d    = LOW;
                        db_d    = '0;
                        hold_d  = '0;
                        rep_d   = '0;
                        lvl_d   = 1'b0;
                        long_d  = 1'b0;
                        rpt_d   = 1'b0;
                        press_d = POR && !long_q;
                    end else begin
                        db_d = db_q + ONE;
                    end
                end
                default: st_d = LOW;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                st_q    <= LOW;
                db_q    <= '0;
                hold_q  <= '0;
                rep_q   <= '0;
                lvl_q   <= 1'b0;
                long_q  <= 1'b0;
                press_q <= 1'b0;
                rpt_q   <= 1'b0;
            end else begin
                s1_q    <= btn_in[i];
                s2_q    <= s1_q;
                st_q    <= st_d;
                db_q    <= db_d;
                hold_q  <= hold_d;
                rep_q   <= rep_d;
                lvl_q   <= lvl_d;
                long_q  <= long_d;
                press_q <= press_d;
                rpt_q   <= rpt_d;
            end
        end

        assign btn_level[i]  = lvl_q;
        assign btn_press[i]  = press_q;
        assign btn_repeat[i] = rpt_q;
        assign btn_long[i]   = long_q;
    end
endmodule

// File: tb/tb_btn_bank_debouncer.sv
// tb_btn_bank_debouncer: directed and random stimulus against a run-length/age model, both press modes.
module tb_btn_bank_debouncer;
    localparam int DB = 20, HOLD = 100, REP = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_in = '0;
    logic [3:0] lvl0, prs0, rpt0, lng0, lvl1, prs1, rpt1, lng1;

    always #5 clk = ~clk;

    btn_bank_debouncer #(.N_BTN(4), .CLK_HZ(10_000), .DEBOUNCE_MS(2), .HOLD_MS(10), .REPEAT_MS(3),
                         .PRESS_ON_RELEASE(0)) dut0 (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(lvl0), .btn_press(prs0),
        .btn_repeat(rpt0), .btn_long(lng0));
    btn_bank_debouncer #(.N_BTN(4), .CLK_HZ(10_000), .DEBOUNCE_MS(2), .HOLD_MS(10), .REPEAT_MS(3),
                         .PRESS_ON_RELEASE(1)) dut1 (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(lvl1), .btn_press(prs1),
        .btn_repeat(rpt1), .btn_long(lng1));

    logic [3:0] syn1, syn2, m_lvl, m_long, m_rpt, m_prs0, m_prs1, pl;
    int run [4];
    int age [4];
    int cyc_n = 0, n_vec = 0, n_err = 0;
    int np0 [4], np1 [4], nrp [4], t_p0 [4], t_p1 [4], t_rf [4], t_rl [4], t_long [4], t_fall [4];

    task automatic model_reset();
        syn1 = '0; syn2 = '0; m_lvl = '0; m_long = '0; m_rpt = '0; m_prs0 = '0; m_prs1 = '0;
        for (int c = 0; c < 4; c++) begin
            run[c] = 0;
            age[c] = 0;
        end
    endtask

    // Level flips after DB consecutive disagreeing samples; long/repeat follow from edges since rise.
    task automatic model_step();
        logic s;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 4; c++) begin
            s = syn2[c];
            syn2[c] = syn1[c];
            syn1[c] = btn_in[c];
            m_prs0[c] = 1'b0;
            m_prs1[c] = 1'b0;
            m_rpt[c] = 1'b0;
            run[c] = (s != m_lvl[c]) ? run[c] + 1 : 0;
            if (run[c] == DB) begin
                run[c] = 0;
                if (!m_lvl[c]) begin
                    m_lvl[c] = 1'b1;
                    age[c] = 0;
                    m_prs0[c] = 1'b1;
                end else begin
                    m_prs1[c] = !m_long[c];
                    m_lvl[c] = 1'b0;
                    m_long[c] = 1'b0;
                end
            end else if (m_lvl[c]) begin
                age[c]++;
                m_long[c] = age[c] >= HOLD;
                m_rpt[c] = age[c] >= HOLD && (age[c] - HOLD) % REP == 0;
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic clr_log();
        for (int c = 0; c < 4; c++) begin
            np0[c] = 0; np1[c] = 0; nrp[c] = 0;
            t_p0[c] = -1; t_p1[c] = -1; t_rf[c] = -1; t_rl[c] = -1; t_long[c] = -1; t_fall[c] = -1;
        end
    endtask

    // One clock: drive, advance model on the edge, compare and log on the falling edge.
    task automatic cyc(input logic [3:0] b);
        btn_in = b;
        @(posedge clk);
        cyc_n++;
        model_step();
        @(negedge clk);
        n_vec++;
        if ({lvl0, prs0, rpt0, lng0} !== {m_lvl, m_prs0, m_rpt, m_long}) begin
            n_err++;
            $display("FAIL mode0 edge %0d: lvl/prs/rpt/lng got %h%h%h%h expected %h%h%h%h", cyc_n,
                     lvl0, prs0, rpt0, lng0, m_lvl, m_prs0, m_rpt, m_long);
        end
        n_vec++;
        if ({lvl1, prs1, rpt1, lng1} !== {m_lvl, m_prs1, m_rpt, m_long}) begin
            n_err++;
            $display("FAIL mode1 edge %0d: lvl/prs/rpt/lng got %h%h%h%h expected %h%h%h%h", cyc_n,
                     lvl1, prs1, rpt1, lng1, m_lvl, m_prs1, m_rpt, m_long);
        end
        for (int c = 0; c < 4; c++) begin
            if (prs0[c]) begin np0[c]++; t_p0[c] = cyc_n; end
            if (prs1[c]) begin np1[c]++; t_p1[c] = cyc_n; end
            if (rpt0[c]) begin
                nrp[c]++;
                if (t_rf[c] < 0) t_rf[c] = cyc_n;
                t_rl[c] = cyc_n;
            end
            if (lng0[c] && t_long[c] < 0) t_long[c] = cyc_n;
            if (pl[c] && !lvl0[c]) t_fall[c] = cyc_n;
        end
        pl = lvl0;
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        repeat (n) cyc(b);
    endtask

    int t0, p;
    int rem [4];
    logic [3:0] cur;

    initial begin
        pl = '0;
        model_reset();
        clr_log();
        #1;
        chk("reset_outputs", int'({lvl0, prs0, rpt0, lng0, lvl1, prs1, rpt1, lng1}), 0);
        hold(4'b0000, 4);
        rst = 1'b0;
        hold(4'b0000, 5);

        // clean short press on ch0
        clr_log();
        t0 = cyc_n + 1;
        hold(4'b0001, 60);
        hold(4'b0000, 40);
        chk("s1_press_count", np0[0], 1);
        chk("s1_press_time", t_p0[0], t0 + 21);
        chk("s1_fall_time", t_fall[0], t0 + 81);
        chk("s1_no_long", t_long[0], -1);
        chk("s1_no_repeat", nrp[0] + nrp[1] + nrp[2] + nrp[3], 0);
        chk("s1_rel_press_time", t_p1[0], t0 + 81);
        chk("s1_rel_press_count", np1[0], 1);

        // bounce on ch1
        clr_log();
        repeat (4) begin
            hold(4'b0010, 15);
            hold(4'b0000, 5);
        end
        chk("s2_no_bounce_event", np0[1], 0);
        t0 = cyc_n + 1;
        hold(4'b0010, 40);
        hold(4'b0000, 40);
        chk("s2_press_count", np0[1], 1);
        chk("s2_press_time", t_p0[1], t0 + 21);

        // long hold on ch2 with four repeats
        clr_log();
        t0 = cyc_n + 1;
        p = t0 + 21;
        hold(4'b0100, 201);
        hold(4'b0000, 40);
        chk("s3_long_time", t_long[2], p + 100);
        chk("s3_repeat_count", nrp[2], 4);
        chk("s3_repeat_first", t_rf[2], p + 100);
        chk("s3_repeat_last", t_rl[2], p + 190);
        chk("s3_fall_time", t_fall[2], p + 201);
        chk("s3_rel_press_none", np1[2], 0);
        chk("s3_press_count", np0[2], 1);

        // simultaneous ch0 and ch3
        clr_log();
        hold(4'b1001, 60);
        hold(4'b0000, 40);
        chk("s5_press_ch0", np0[0], 1);
        chk("s5_press_ch3", np0[3], 1);
        chk("s5_same_cycle", t_p0[3], t_p0[0]);
        chk("s5_others_quiet", np0[1] + np0[2], 0);

        // reset while ch2 is long-pressed
        clr_log();
        hold(4'b0100, 21 + 110);
        chk("s6_long_before_rst", int'(lng0[2]), 1);
        rst = 1'b1;
        #1;
        chk("s6_outputs_in_rst", int'({lvl0, prs0, rpt0, lng0, lvl1, prs1, rpt1, lng1}), 0);
        model_reset();
        hold(4'b0100, 3);
        rst = 1'b0;
        clr_log();
        t0 = cyc_n + 1;
        hold(4'b0100, 40);
        chk("s6_fresh_press_time", t_p0[2], t0 + 21);
        chk("s6_no_rel_event", np1[2], 0);
        hold(4'b0000, 40);

        // random runs per channel
        for (int c = 0; c < 4; c++) rem[c] = 0;
        cur = '0;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (rem[c] == 0) begin
                    cur[c] = 1'($urandom_range(0, 1));
                    rem[c] = $urandom_range(1, 150);
                end
                rem[c]--;
            end
            if (i == 2500) begin
                rst = 1'b1;
                model_reset();
            end
            if (i == 2503) rst = 1'b0;
            cyc(cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
